// File: rtl/mem_update_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_update_arbiter_if
// Purpose : bundles the command, handshake and status signals that pass
//           between the command sources (GameControl / Interboard), the
//           update arbiter and the MemoryHandle update port.
// Signals : ctrl_en/ctrl_cmd     local command strobe + 22-bit command
//           inter_en/inter_cmd   remote command strobe + 22-bit command
//           mem_done             memory finished the current command
//           ctrl_ready/inter_ready  per-source FIFO not full
//           mem_en/mem_src/mem_cmd  issue strobe, source id, issued command
//           busy, ovf_ctrl, ovf_inter, timeout_err  status / sticky flags
// Modports: slave  = arbiter side, master = environment side
// ---------------------------------------------------------------------------
interface mem_update_arbiter_if;
   logic        ctrl_en;
   logic [21:0] ctrl_cmd;
   logic        inter_en;
   logic [21:0] inter_cmd;
   logic        mem_done;
   logic        ctrl_ready;
   logic        inter_ready;
   logic        mem_en;
   logic        mem_src;
   logic [21:0] mem_cmd;
   logic        busy;
   logic        ovf_ctrl;
   logic        ovf_inter;
   logic        timeout_err;

   modport slave (
      input  ctrl_en, ctrl_cmd, inter_en, inter_cmd, mem_done,
      output ctrl_ready, inter_ready, mem_en, mem_src, mem_cmd,
             busy, ovf_ctrl, ovf_inter, timeout_err
   );

   modport master (
      output ctrl_en, ctrl_cmd, inter_en, inter_cmd, mem_done,
      input  ctrl_ready, inter_ready, mem_en, mem_src, mem_cmd,
             busy, ovf_ctrl, ovf_inter, timeout_err
   );
endinterface

// File: rtl/mem_update_arbiter.sv
// ---------------------------------------------------------------------------
// mem_update_arbiter
// Purpose : shares the single MemoryHandle update port between local
//           (ctrl) and remote (inter) commands. Each source owns a FIFO; a
//           round-robin arbiter issues one command at a time and waits for
//           mem_done (or a timeout) before issuing the next.
// Ports   : clk             system clock
//           rst             synchronous reset, active-low
//           interboard_rst  synchronous flush, active-high (same effect)
//           bus             mem_update_arbiter_if.slave (see interface)
// Params  : DEPTH    entries per source FIFO (power of 2, >= 2)
//           TIMEOUT  WAIT cycles before a forced return to IDLE (< 1024)
// ---------------------------------------------------------------------------
module mem_update_arbiter #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  interboard_rst,
   mem_update_arbiter_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = 22;
   localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [9:0]  TIMEOUT_C = 10'(TIMEOUT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // FIFO storage and wrap-around pointers (extra MSB distinguishes full/empty)
   logic [CW-1:0] r_c_mem [DEPTH];
   logic [CW-1:0] r_i_mem [DEPTH];
   logic [AW:0]   r_c_wp;
   logic [AW:0]   r_c_rp;
   logic [AW:0]   r_i_wp;
   logic [AW:0]   r_i_rp;

   // Arbiter / issue state
   state_t        r_state;
   logic [9:0]    r_wait_cnt;
   logic          r_last_grant;
   logic          r_mem_en;
   logic          r_mem_src;
   logic [CW-1:0] r_mem_cmd;
   logic          r_ovf_ctrl;
   logic          r_ovf_inter;
   logic          r_timeout_err;

   logic          w_flush;
   logic          w_c_empty;
   logic          w_c_full;
   logic          w_i_empty;
   logic          w_i_full;
   logic          w_grant;
   logic          w_grant_src;
   logic          w_pop_c;
   logic          w_pop_i;
   logic          w_push_c_ok;
   logic          w_push_i_ok;
   logic [9:0]    w_cnt_nxt;
   logic          w_timeout_hit;
   logic          w_done_seen;

   assign w_flush   = (~rst) | interboard_rst;

   assign w_c_empty = (r_c_wp == r_c_rp);
   assign w_i_empty = (r_i_wp == r_i_rp);
   assign w_c_full  = (r_c_wp[AW] != r_c_rp[AW]) && (r_c_wp[AW-1:0] == r_c_rp[AW-1:0]);
   assign w_i_full  = (r_i_wp[AW] != r_i_rp[AW]) && (r_i_wp[AW-1:0] == r_i_rp[AW-1:0]);

   assign w_grant   = (r_state == ST_IDLE) && (!w_c_empty || !w_i_empty);
   assign w_pop_c   = w_grant && !w_grant_src;
   assign w_pop_i   = w_grant &&  w_grant_src;

   // A pop at the same edge frees a slot, so a push into a full FIFO still lands
   assign w_push_c_ok = !w_c_full || w_pop_c;
   assign w_push_i_ok = !w_i_full || w_pop_i;

   // The counter "reaches" TIMEOUT at the edge where its next value equals it
   assign w_cnt_nxt     = r_wait_cnt + 10'd1;
   assign w_timeout_hit = (w_cnt_nxt == TIMEOUT_C);
   // mem_done arriving in the issue cycle belongs to an older command
   assign w_done_seen   = bus.mem_done && !r_mem_en;

   // Round-robin winner: a lone non-empty source wins, a tie goes to the other source
   always_comb begin
      w_grant_src = 1'b0;
      if (!w_c_empty && !w_i_empty) begin
         w_grant_src = ~r_last_grant;
      end else if (!w_i_empty) begin
         w_grant_src = 1'b1;
      end else begin
         w_grant_src = 1'b0;
      end
   end

   // FIFO entry storage; contents need no reset because pointers gate validity
   always_ff @(posedge clk) begin
      if (bus.ctrl_en && w_push_c_ok) begin
         r_c_mem[r_c_wp[AW-1:0]] <= bus.ctrl_cmd;
      end
      if (bus.inter_en && w_push_i_ok) begin
         r_i_mem[r_i_wp[AW-1:0]] <= bus.inter_cmd;
      end
   end

   // FIFO pointers and sticky overflow flags
   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_c_wp      <= '0;
         r_c_rp      <= '0;
         r_i_wp      <= '0;
         r_i_rp      <= '0;
         r_ovf_ctrl  <= 1'b0;
         r_ovf_inter <= 1'b0;
      end else begin
         if (bus.ctrl_en) begin
            if (w_push_c_ok) begin
               r_c_wp <= r_c_wp + PTR_ONE;
            end else begin
               r_ovf_ctrl <= 1'b1;
            end
         end
         if (bus.inter_en) begin
            if (w_push_i_ok) begin
               r_i_wp <= r_i_wp + PTR_ONE;
            end else begin
               r_ovf_inter <= 1'b1;
            end
         end
         if (w_pop_c) begin
            r_c_rp <= r_c_rp + PTR_ONE;
         end
         if (w_pop_i) begin
            r_i_rp <= r_i_rp + PTR_ONE;
         end
      end
   end

   // Issue FSM: grant from IDLE, then wait for mem_done or timeout
   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_state       <= ST_IDLE;
         r_wait_cnt    <= 10'd0;
         r_last_grant  <= 1'b1;
         r_mem_en      <= 1'b0;
         r_mem_src     <= 1'b0;
         r_mem_cmd     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_mem_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_mem_en     <= 1'b1;
                  r_mem_src    <= w_grant_src;
                  r_mem_cmd    <= w_grant_src ? r_i_mem[r_i_rp[AW-1:0]]
                                              : r_c_mem[r_c_rp[AW-1:0]];
                  r_last_grant <= w_grant_src;
                  r_wait_cnt   <= 10'd0;
                  r_state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_done_seen) begin
                  r_wait_cnt <= 10'd0;
                  r_state    <= ST_IDLE;
               end else if (w_timeout_hit) begin
                  r_timeout_err <= 1'b1;
                  r_wait_cnt    <= 10'd0;
                  r_state       <= ST_IDLE;
               end else begin
                  r_wait_cnt <= w_cnt_nxt;
               end
            end
            default: begin
               r_wait_cnt <= 10'd0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ctrl_ready  = !w_c_full;
   assign bus.inter_ready = !w_i_full;
   assign bus.mem_en      = r_mem_en;
   assign bus.mem_src     = r_mem_src;
   assign bus.mem_cmd     = r_mem_cmd;
   assign bus.busy        = (r_state == ST_WAIT) || !w_c_empty || !w_i_empty;
   assign bus.ovf_ctrl    = r_ovf_ctrl;
   assign bus.ovf_inter   = r_ovf_inter;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_update_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_update_arbiter
// Purpose : self-checking bench for mem_update_arbiter. A transaction-level
//           model (two command queues, a waiting flag and a cycle count)
//           predicts every output each cycle; directed scenarios add
//           hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_update_arbiter;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 1023;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ib_rst = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_issue = 0;

   mem_update_arbiter_if bus ();

   mem_update_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .interboard_rst (ib_rst),
      .bus            (bus.slave)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [21:0] qc[$];
   logic [21:0] qi[$];
   logic        m_en, m_src, m_ovf_c, m_ovf_i, m_tout, m_wait, m_last;
   logic [21:0] m_cmd;
   int          m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      logic g;
      logic s;
      if (!rst || ib_rst) begin
         qc.delete(); qi.delete();
         m_en = 1'b0; m_src = 1'b0; m_cmd = 22'd0;
         m_ovf_c = 1'b0; m_ovf_i = 1'b0; m_tout = 1'b0;
         m_wait = 1'b0; m_cnt = 0; m_last = 1'b1;
         return;
      end
      g = !m_wait && (qc.size() > 0 || qi.size() > 0);
      s = (qc.size() > 0 && qi.size() > 0) ? !m_last : (qc.size() == 0);
      if (m_wait) begin
         if (bus.mem_done && !m_en) begin
            m_wait = 1'b0;
         end else begin
            m_cnt++;
            if (m_cnt == TIMEOUT) begin
               m_wait = 1'b0;
               m_tout = 1'b1;
            end
         end
      end
      if (g) begin
         m_cmd  = s ? qi.pop_front() : qc.pop_front();
         m_src  = s;
         m_last = s;
         m_wait = 1'b1;
         m_cnt  = 0;
      end
      if (bus.ctrl_en) begin
         if (qc.size() < DEPTH) qc.push_back(bus.ctrl_cmd);
         else m_ovf_c = 1'b1;
      end
      if (bus.inter_en) begin
         if (qi.size() < DEPTH) qi.push_back(bus.inter_cmd);
         else m_ovf_i = 1'b1;
      end
      m_en = g;
   endtask

   // Model advances on each edge; outputs are compared 1 time unit later
   always @(posedge clk) begin
      model_step();
      #1;
      check("ctrl_ready",  bus.ctrl_ready,  qc.size() < DEPTH);
      check("inter_ready", bus.inter_ready, qi.size() < DEPTH);
      check("mem_en",      bus.mem_en,      m_en);
      check("mem_src",     bus.mem_src,     m_src);
      check("mem_cmd",     bus.mem_cmd,     m_cmd);
      check("busy",        bus.busy,        m_wait || qc.size() > 0 || qi.size() > 0);
      check("ovf_ctrl",    bus.ovf_ctrl,    m_ovf_c);
      check("ovf_inter",   bus.ovf_inter,   m_ovf_i);
      check("timeout_err", bus.timeout_err, m_tout);
      if (bus.mem_en) n_issue++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      bus.ctrl_en = 1'b0; bus.inter_en = 1'b0; bus.mem_done = 1'b0;
      bus.ctrl_cmd = 22'd0; bus.inter_cmd = 22'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_mem_en(input int max_cyc, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (bus.mem_en) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_mem_en: no issue within %0d cycles", max_cyc);
      end
   endtask

   task automatic pulse_done();
      @(negedge clk); bus.mem_done = 1'b1;
      @(negedge clk); bus.mem_done = 1'b0;
   endtask

   task automatic push_ctrl(input logic [21:0] c);
      @(negedge clk);
      bus.ctrl_en = 1'b1; bus.ctrl_cmd = c;
   endtask

   task automatic push_inter(input logic [21:0] c);
      @(negedge clk);
      bus.inter_en = 1'b1; bus.inter_cmd = c;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic        ok;
      logic        srcs [4];
      logic [21:0] cmds [4];
      int          k;

      idle_inputs();
      do_reset();

      // 1: single ctrl command, issue latency and held outputs
      push_ctrl(22'h2ABCDE);
      @(negedge clk); bus.ctrl_en = 1'b0;
      check("t1_no_issue_yet", bus.mem_en, 1'b0);
      check("t1_busy",         bus.busy,   1'b1);
      @(negedge clk);
      check("t1_mem_en",  bus.mem_en,  1'b1);
      check("t1_mem_src", bus.mem_src, 1'b0);
      check("t1_mem_cmd", bus.mem_cmd, 22'h2ABCDE);
      @(negedge clk);
      check("t1_one_pulse", bus.mem_en, 1'b0);
      @(negedge clk); bus.mem_done = 1'b1;
      @(negedge clk); bus.mem_done = 1'b0;
      check("t1_busy_drop", bus.busy,    1'b0);
      check("t1_cmd_held",  bus.mem_cmd, 22'h2ABCDE);

      // 2: simultaneous sources alternate ctrl, inter, ctrl, inter
      do_reset();
      @(negedge clk);
      bus.ctrl_en = 1'b1; bus.ctrl_cmd = 22'h000C01;
      bus.inter_en = 1'b1; bus.inter_cmd = 22'h000A01;
      @(negedge clk);
      bus.ctrl_cmd = 22'h000C02; bus.inter_cmd = 22'h000A02;
      @(negedge clk);
      bus.ctrl_en = 1'b0; bus.inter_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_mem_en(20, ok);
         srcs[i] = bus.mem_src;
         cmds[i] = bus.mem_cmd;
         pulse_done();
      end
      check("t2_src0", srcs[0], 1'b0); check("t2_cmd0", cmds[0], 22'h000C01);
      check("t2_src1", srcs[1], 1'b1); check("t2_cmd1", cmds[1], 22'h000A01);
      check("t2_src2", srcs[2], 1'b0); check("t2_cmd2", cmds[2], 22'h000C02);
      check("t2_src3", srcs[3], 1'b1); check("t2_cmd3", cmds[3], 22'h000A02);

      // 3: six ctrl pushes with mem_done withheld -> one dropped, five issued
      do_reset();
      @(negedge clk);
      n_issue = 0;
      for (int i = 0; i < 6; i++) push_ctrl(22'h100 + 22'(i));
      @(negedge clk); bus.ctrl_en = 1'b0;
      check("t3_ready_low", bus.ctrl_ready, 1'b0);
      check("t3_ovf",       bus.ovf_ctrl,   1'b1);
      for (int i = 0; i < 6; i++) begin
         repeat (3) @(negedge clk);
         pulse_done();
      end
      repeat (5) @(negedge clk);
      check("t3_issue_count", n_issue,     5);
      check("t3_last_cmd",    bus.mem_cmd, 22'h104);

      // 4: no mem_done -> timeout exactly TIMEOUT cycles after issue, then next cmd
      do_reset();
      push_ctrl(22'h0BEEF0);
      push_ctrl(22'h0BEEF1);
      @(negedge clk); bus.ctrl_en = 1'b0;
      check("t4_first_issue", bus.mem_en, 1'b1);
      k = 0;
      while (!bus.timeout_err && k < TIMEOUT + 20) begin
         @(negedge clk);
         k++;
      end
      check("t4_timeout_cycles", k, TIMEOUT);
      wait_mem_en(5, ok);
      check("t4_next_cmd", bus.mem_cmd,     22'h0BEEF1);
      check("t4_sticky",   bus.timeout_err, 1'b1);

      // 5: interboard_rst mid-WAIT flushes everything
      do_reset();
      for (int i = 0; i < 6; i++) push_ctrl(22'h200 + 22'(i));
      @(negedge clk); bus.ctrl_en = 1'b0;
      check("t5_ovf_before", bus.ovf_ctrl, 1'b1);
      ib_rst = 1'b1;
      @(negedge clk); ib_rst = 1'b0;
      n_issue = 0;
      repeat (20) @(negedge clk);
      check("t5_no_issue", n_issue,         0);
      check("t5_busy",     bus.busy,        1'b0);
      check("t5_ovf",      bus.ovf_ctrl,    1'b0);
      check("t5_tout",     bus.timeout_err, 1'b0);
      check("t5_cmd_zero", bus.mem_cmd,     22'h0);

      // 6: push into a full inter FIFO at the edge it is popped
      do_reset();
      for (int i = 0; i < 5; i++) push_inter(22'h300 + 22'(i));
      @(negedge clk); bus.inter_en = 1'b0; bus.mem_done = 1'b1;
      check("t6_full", bus.inter_ready, 1'b0);
      @(negedge clk); bus.mem_done = 1'b0;
      bus.inter_en = 1'b1; bus.inter_cmd = 22'h305;
      @(negedge clk); bus.inter_en = 1'b0;
      check("t6_no_ovf",    bus.ovf_inter,   1'b0);
      check("t6_still_full", bus.inter_ready, 1'b0);
      check("t6_popped",    bus.mem_cmd,     22'h301);
      for (int i = 0; i < 4; i++) begin
         repeat (3) @(negedge clk);
         pulse_done();
      end
      repeat (3) @(negedge clk);
      check("t6_last_cmd", bus.mem_cmd,   22'h305);
      check("t6_ovf_end",  bus.ovf_inter, 1'b0);

      // Random traffic: sparse then dense pushes, random done, rare flushes
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (i < 1500) begin
            bus.ctrl_en  = ($urandom_range(7) == 0);
            bus.inter_en = ($urandom_range(7) == 0);
         end else begin
            bus.ctrl_en  = ($urandom_range(1) == 0);
            bus.inter_en = ($urandom_range(1) == 0);
         end
         bus.ctrl_cmd  = 22'($urandom());
         bus.inter_cmd = 22'($urandom());
         bus.mem_done  = ($urandom_range(3) == 0);
         ib_rst        = ($urandom_range(499) == 0);
      end
      @(negedge clk);
      idle_inputs();
      ib_rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
